// File: rtl/spi_slave.sv
// SPI slave with a single-entry receive buffer and a per-frame transmit word.
// The SPI pins are synchronised into clk; frames are LSB first.
module spi_slave #(
    parameter int CPOL       = 0,
    parameter int FRAME_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss_n,
    output logic                  miso,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  frame_err
);

    localparam int   CW       = $clog2(FRAME_BITS + 1);
    localparam int   IW       = $clog2(FRAME_BITS);
    localparam logic IDLE_LVL = 1'(CPOL);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_DESEL} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  miso_q, miso_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  word_done_q, word_done_d;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    logic          sclk_changed, sample_edge, shift_edge, ss_fall;
    logic [IW-1:0] idx;

    assign sclk_changed = sclk_sync_q != sclk_prev_q;
    assign sample_edge  = sclk_changed && (sclk_sync_q != IDLE_LVL);
    assign shift_edge   = sclk_changed && (sclk_sync_q == IDLE_LVL);
    assign ss_fall      = ss_prev_q && !ss_sync_q;
    assign idx          = bit_cnt_q[IW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_meta_q <= IDLE_LVL;
            sclk_sync_q <= IDLE_LVL;
            sclk_prev_q <= IDLE_LVL;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            ss_meta_q   <= ss_n;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            tx_ready_q  <= tx_ready_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;
        tx_ready_d  = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        word_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    if (tx_valid) begin
                        tx_shift_d = tx_data;
                        miso_d     = tx_data[0];
                        tx_ready_d = 1'b1;
                    end else begin
                        tx_shift_d = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (ss_sync_q) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    miso_d      = 1'b0;
                    frame_err_d = 1'b1;
                end else if (sample_edge) begin
                    rx_shift_d[idx] = mosi_sync_q;
                    bit_cnt_d       = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
                        state_d     = WAIT_DESEL;
                        word_done_d = 1'b1;
                    end
                end else if (shift_edge && bit_cnt_q != '0) begin
                    // bit_cnt already counts the sampled bits, so it points at the next bit out
                    miso_d = tx_shift_q[idx];
                end
            end
            WAIT_DESEL: begin
                if (ss_sync_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rx_shift_q holds the full word one cycle after the final sample
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (word_done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_ready  = tx_ready_q;
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a CPOL=0/32-bit and a CPOL=1/8-bit instance driven by
// a bit-level SPI master task, with expectations taken from the frame rules.
module tb_spi_slave;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        sclk_a, mosi_a, ss_n_a, miso_a, rx_valid_a, rx_ready_a, tx_valid_a;
    logic        tx_ready_a, busy_a, overrun_a, underrun_a, frame_err_a;
    logic [31:0] rx_data_a, tx_data_a;

    logic        sclk_b, mosi_b, ss_n_b, miso_b, rx_valid_b, rx_ready_b, tx_valid_b;
    logic        tx_ready_b, busy_b, overrun_b, underrun_b, frame_err_b;
    logic [7:0]  rx_data_b, tx_data_b;

    spi_slave #(.CPOL(0), .FRAME_BITS(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .sclk(sclk_a), .mosi(mosi_a), .ss_n(ss_n_a),
        .miso(miso_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .busy(busy_a),
        .overrun(overrun_a), .underrun(underrun_a), .frame_err(frame_err_a)
    );

    spi_slave #(.CPOL(1), .FRAME_BITS(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .sclk(sclk_b), .mosi(mosi_b), .ss_n(ss_n_b),
        .miso(miso_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b),
        .overrun(overrun_b), .underrun(underrun_b), .frame_err(frame_err_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Pulse and occupancy counters sampled mid-cycle
    int n_txr_a = 0, n_ovr_a = 0, n_und_a = 0, n_fe_a = 0, n_rxv_a = 0;
    int n_txr_b = 0, n_ovr_b = 0;
    always @(negedge clk) begin
        if (tx_ready_a)  n_txr_a <= n_txr_a + 1;
        if (overrun_a)   n_ovr_a <= n_ovr_a + 1;
        if (underrun_a)  n_und_a <= n_und_a + 1;
        if (frame_err_a) n_fe_a  <= n_fe_a + 1;
        if (rx_valid_a)  n_rxv_a <= n_rxv_a + 1;
        if (tx_ready_b)  n_txr_b <= n_txr_b + 1;
        if (overrun_b)   n_ovr_b <= n_ovr_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pins(input int inst, input logic s, input logic m, input logic ss);
        if (inst == 0) begin
            sclk_a = s; mosi_a = m; ss_n_a = ss;
        end else begin
            sclk_b = s; mosi_b = m; ss_n_b = ss;
        end
    endtask

    // Master: shifts mosi out on the idle-going edge, samples miso on the active edge.
    // nsend < frame length releases ss_n mid-frame.
    task automatic spi_frame(input int inst, input logic [31:0] word, input int nsend,
                             output logic [31:0] got);
        logic lvl;
        lvl = (inst == 0) ? 1'b0 : 1'b1;
        got = '0;
        set_pins(inst, lvl, 1'b0, 1'b0);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nsend; i++) begin
            set_pins(inst, lvl, word[i], 1'b0);
            repeat (HALF) @(negedge clk);
            set_pins(inst, ~lvl, word[i], 1'b0);
            got[i] = (inst == 0) ? miso_a : miso_b;
            repeat (HALF) @(negedge clk);
        end
        set_pins(inst, lvl, 1'b0, 1'b0);
        repeat (HALF) @(negedge clk);
        set_pins(inst, lvl, 1'b0, 1'b1);
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic consume_a();
        @(negedge clk) rx_ready_a = 1'b1;
        @(negedge clk) rx_ready_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic consume_b();
        @(negedge clk) rx_ready_b = 1'b1;
        @(negedge clk) rx_ready_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] got, word, txw;
        logic        tv;
        int          c_txr, c_ovr, c_und, c_fe, c_rxv;

        reset_n = 1'b0;
        set_pins(0, 1'b0, 1'b0, 1'b1);
        set_pins(1, 1'b1, 1'b0, 1'b1);
        rx_ready_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = '0;
        rx_ready_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = '0;
        repeat (4) @(negedge clk);
        check("rst_rx_valid", 32'(rx_valid_a), 0);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_miso_busy", {30'd0, miso_a, busy_a}, 0);
        check("rst_pulses", {28'd0, tx_ready_a, overrun_a, underrun_a, frame_err_a}, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic full-duplex frame
        tx_data_a = 32'hA5A5_0F0F; tx_valid_a = 1'b1;
        c_txr = n_txr_a;
        spi_frame(0, 32'h1234_5678, 32, got);
        check("f1_rx_data", rx_data_a, 32'h1234_5678);
        check("f1_rx_valid", 32'(rx_valid_a), 1);
        check("f1_master_rx", got, 32'hA5A5_0F0F);
        check("f1_tx_ready_cnt", n_txr_a - c_txr, 1);
        check("f1_busy_after", 32'(busy_a), 0);
        check("f1_miso_idle", 32'(miso_a), 0);
        consume_a();
        check("f1_consumed", 32'(rx_valid_a), 0);

        // Two frames without consuming: second one overruns
        c_ovr = n_ovr_a;
        spi_frame(0, 32'h1, 32, got);
        check("ovr_first_none", n_ovr_a - c_ovr, 0);
        spi_frame(0, 32'h2, 32, got);
        check("ovr_rx_data", rx_data_a, 32'h1);
        check("ovr_cnt", n_ovr_a - c_ovr, 1);
        consume_a();

        // Consumer always ready
        rx_ready_a = 1'b1;
        c_rxv = n_rxv_a; c_ovr = n_ovr_a;
        spi_frame(0, 32'h1234_5678, 32, got);
        check("rdy_master_rx", got, 32'hA5A5_0F0F);
        spi_frame(0, 32'h1234_5678, 32, got);
        check("rdy_valid_cycles", n_rxv_a - c_rxv, 2);
        check("rdy_no_overrun", n_ovr_a - c_ovr, 0);
        check("rdy_rx_data", rx_data_a, 32'h1234_5678);
        check("rdy_rx_valid", 32'(rx_valid_a), 0);

        // Underrun: nothing to send
        tx_valid_a = 1'b0;
        c_und = n_und_a; c_txr = n_txr_a;
        spi_frame(0, 32'h0BAD_F00D, 32, got);
        check("und_cnt", n_und_a - c_und, 1);
        check("und_master_rx", got, 32'h0);
        check("und_no_tx_ready", n_txr_a - c_txr, 0);
        rx_ready_a = 1'b0;

        // Aborted frame then a clean one
        tx_valid_a = 1'b1;
        c_fe = n_fe_a;
        spi_frame(0, 32'hFFFF_FFFF, 10, got);
        check("fe_cnt", n_fe_a - c_fe, 1);
        check("fe_rx_valid", 32'(rx_valid_a), 0);
        check("fe_busy", 32'(busy_a), 0);
        spi_frame(0, 32'hDEAD_BEEF, 32, got);
        check("fe_next_rx_data", rx_data_a, 32'hDEAD_BEEF);
        check("fe_next_rx_valid", 32'(rx_valid_a), 1);
        check("fe_next_master_rx", got, 32'hA5A5_0F0F);
        consume_a();

        // CPOL=1, 8-bit frame
        tx_data_b = 8'hC3; tx_valid_b = 1'b1;
        spi_frame(1, 32'h3C, 8, got);
        check("b_rx_data", 32'(rx_data_b), 32'h3C);
        check("b_rx_valid", 32'(rx_valid_b), 1);
        check("b_master_rx", got, 32'hC3);
        check("b_tx_ready_cnt", n_txr_b, 1);
        consume_b();

        // Reset mid-frame aborts silently
        c_fe = n_fe_a;
        set_pins(0, 1'b0, 1'b1, 1'b0);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_pins(0, 1'b1, 1'b1, 1'b0);
            repeat (HALF) @(negedge clk);
            set_pins(0, 1'b0, 1'b1, 1'b0);
            repeat (HALF) @(negedge clk);
        end
        check("mid_busy_before", 32'(busy_a), 1);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy_a), 0);
        check("mid_miso", 32'(miso_a), 0);
        set_pins(0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_no_frame_err", n_fe_a - c_fe, 0);
        check("mid_rx_valid", 32'(rx_valid_a), 0);

        // Randomised frames against the frame-level model
        for (int k = 0; k < 6; k++) begin
            word = $urandom;
            txw  = $urandom;
            tv   = 1'($urandom_range(0, 1));
            tx_data_a = txw; tx_valid_a = tv;
            c_und = n_und_a;
            spi_frame(0, word, 32, got);
            check($sformatf("rnd_a%0d_master_rx", k), got, tv ? txw : 32'h0);
            check($sformatf("rnd_a%0d_rx_data", k), rx_data_a, word);
            check($sformatf("rnd_a%0d_underrun", k), n_und_a - c_und, tv ? 0 : 1);
            consume_a();
        end
        for (int k = 0; k < 4; k++) begin
            word = 32'($urandom_range(0, 255));
            txw  = 32'($urandom_range(0, 255));
            tx_data_b = txw[7:0]; tx_valid_b = 1'b1;
            spi_frame(1, word, 8, got);
            check($sformatf("rnd_b%0d_master_rx", k), got, txw);
            check($sformatf("rnd_b%0d_rx_data", k), 32'(rx_data_b), word);
            consume_b();
        end
        check("b_no_overrun", n_ovr_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter CPOL, default 0, idle level of sclk; 0: sample on sclk rise, shift miso on sclk fall; 1: sample on fall, shift on rise.
REQ-002 Parameter FRAME_BITS, default 32, bits per frame; legal range 8..32.
REQ-003 clk  input  1  system clock; all logic in this domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  SPI serial clock from master; asynchronous to clk.
REQ-006 mosi  input  1  serial data from master, LSB first.
REQ-007 ss_n  input  1  active-low slave select.
REQ-008 miso  output  1  serial data to master, LSB first.
REQ-009 rx_data  output  FRAME_BITS  last complete received frame.
REQ-010 rx_valid  output  1  rx_data holds an unconsumed frame.
REQ-011 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-012 tx_data  input  FRAME_BITS  word to transmit in next frame.
REQ-013 tx_valid  input  1  tx_data is valid.
REQ-014 tx_ready  output  1  one-cycle pulse: tx_data captured.
REQ-015 busy  output  1  high while state is ACTIVE or WAIT_DESEL.
REQ-016 overrun  output  1  one-cycle pulse: completed frame dropped, rx buffer full.
REQ-017 underrun  output  1  one-cycle pulse: frame started with tx_valid low.
REQ-018 frame_err  output  1  one-cycle pulse: ss_n deasserted mid-frame.

Function
REQ-019 sclk, mosi, ss_n shall pass through a two-flop synchroniser; edges detected on synchronised sclk (third flop); sclk half-period shall be >= 3 clk cycles (master divider >= 3).
REQ-020 States: IDLE, ACTIVE, WAIT_DESEL.
REQ-021 IDLE -> ACTIVE on synchronised ss_n falling edge; bit_cnt cleared; tx shift register loaded with tx_data and tx_ready pulsed if tx_valid, else loaded with 0 and underrun pulsed; miso driven with bit 0 on the same cycle.
REQ-022 ACTIVE: on each sample edge rx_shift[bit_cnt] <= synchronised mosi, bit_cnt increments; on each shift edge after first sample miso <= tx_shift[bit_cnt].
REQ-023 ACTIVE -> WAIT_DESEL on the sample edge capturing bit FRAME_BITS-1; the complete word is offered to rx buffer on the following cycle.
REQ-024 Rx buffer single entry: if rx_valid low or rx_ready high that cycle, rx_data <= word, rx_valid <= 1; otherwise word discarded, rx_data unchanged, overrun pulsed.
REQ-025 rx_valid clears on rx_valid && rx_ready with no simultaneous new word.
REQ-026 WAIT_DESEL -> IDLE on synchronised ss_n high; further sclk edges in WAIT_DESEL ignored, miso held.
REQ-027 ss_n high while ACTIVE: partial frame discarded, frame_err pulsed, -> IDLE; rx buffer untouched.
REQ-028 miso = 0 in IDLE.
REQ-029 sclk edges in IDLE ignored.

Reset
REQ-030 reset_n low: state IDLE, miso 0, rx_data 0, rx_valid 0, tx_ready/overrun/underrun/frame_err 0, busy 0, bit_cnt 0, synchronisers to idle values (sclk CPOL, ss_n 1, mosi 0); reset mid-frame aborts without flags.

Verification
REQ-031 tx_data=0xA5A5_0F0F valid, master sends 0x1234_5678 CPOL=0 -> rx_data=0x1234_5678, rx_valid=1, master receives 0xA5A5_0F0F, one tx_ready pulse.
REQ-032 Two frames 0x1, 0x2 with rx_ready=0 -> rx_data=0x1, overrun pulse once after frame two.
REQ-033 Same as 031 with rx_ready=1 throughout -> rx_valid high one cycle per frame, no overrun.
REQ-034 tx_valid=0 at ss_n fall -> underrun pulse, master receives 0x0000_0000.
REQ-035 ss_n released after 10 bits -> frame_err pulse, rx_valid unchanged, next full frame 0xDEAD_BEEF received correctly.
REQ-036 CPOL=1, FRAME_BITS=8, sends 0x3C with tx 0xC3 -> rx_data=0x3C, master receives 0xC3.
